// File: rtl/aes_round_sched.sv
// Iterative AES encryption round sequencer: one state register, one MixColumns datapath,
// round keys fetched by index and the S-box layer ported out for sharing.
module aes_round_sched #(
    parameter int unsigned NR = 10
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic [127:0] sb_in,
    input  logic [127:0] sb_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRound = 2'd1;
    localparam logic [1:0] StFinal = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [3:0] RndLast  = 4'(NR - 1);
    localparam logic [3:0] RndFinal = 4'(NR);

    logic [1:0]   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] sr_out;
    logic [127:0] mc_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte (r,c) sits at bits [127-8*(4c+r) -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]), mix_column(s[31:0])};
    endfunction

    assign sr_out = shift_rows(sb_out);
    assign mc_out = mix_columns(sr_out);

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    st_d    = in_data ^ rk;
                    rnd_d   = 4'd1;
                    state_d = StRound;
                end
            end
            StRound: begin
                st_d  = mc_out ^ rk;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == RndLast) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                st_d    = sr_out ^ rk;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    rnd_d   = 4'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            rnd_q   <= 4'd0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        rk_idx = 4'd0;
        case (state_q)
            StRound: rk_idx = rnd_q;
            StFinal: rk_idx = RndFinal;
            default: rk_idx = 4'd0;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sb_in     = st_q;
    assign out_data  = st_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: NR=10 and NR=14 instances with a behavioural S-box and key store,
// FIPS-197 vectors from a table plus handshake, backpressure and reset sequences.
module tb_aes_round_sched;

    localparam int NRA = 10;

    typedef struct {
        logic [255:0] key;
        int           nk;
        logic [127:0] pt;
        logic [127:0] ct;
        int           which;
    } vec_t;

    logic clk;
    logic rst;

    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [127:0] in_data_a, rk_a, sb_in_a, sb_out_a, out_data_a;
    logic [3:0]   rk_idx_a;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [127:0] in_data_b, rk_b, sb_in_b, sb_out_b, out_data_b;
    logic [3:0]   rk_idx_b;

    logic [7:0]   sbox [0:255];
    logic [127:0] rks_a [0:15];
    logic [127:0] rks_b [0:15];

    int   errors;
    int   checks;
    vec_t vecs [3];

    aes_round_sched #(.NR(10)) dut_a (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .in_valid (in_valid_a),
        .in_ready (in_ready_a),
        .in_data  (in_data_a),
        .rk_idx   (rk_idx_a),
        .rk       (rk_a),
        .sb_in    (sb_in_a),
        .sb_out   (sb_out_a),
        .out_valid(out_valid_a),
        .out_ready(out_ready_a),
        .out_data (out_data_a),
        .busy     (busy_a)
    );

    aes_round_sched #(.NR(14)) dut_b (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .in_valid (in_valid_b),
        .in_ready (in_ready_b),
        .in_data  (in_data_b),
        .rk_idx   (rk_idx_b),
        .rk       (rk_b),
        .sb_in    (sb_in_b),
        .sb_out   (sb_out_b),
        .out_valid(out_valid_b),
        .out_ready(out_ready_b),
        .out_data (out_data_b),
        .busy     (busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational key store and S-box layer seen by each instance.
    always_comb begin
        rk_a     = rks_a[rk_idx_a];
        rk_b     = rks_b[rk_idx_b];
        sb_out_a = '0;
        sb_out_b = '0;
        for (int i = 0; i < 16; i++) begin
            sb_out_a[8 * i +: 8] = sbox[sb_in_a[8 * i +: 8]];
            sb_out_b[8 * i +: 8] = sbox[sb_in_b[8 * i +: 8]];
        end
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Key is left-aligned in 256 bits; nk is 4 or 8 words.
    task automatic expand_key(input logic [255:0] key, input int nk, input int which);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (which == 0) rks_a[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
            else            rks_b[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ov(input int which);
        return (which == 0) ? out_valid_a : out_valid_b;
    endfunction

    task automatic drive(input int which, input logic v, input logic [127:0] d, input logic r);
        if (which == 0) begin
            in_valid_a = v; in_data_a = d; out_ready_a = r;
        end else begin
            in_valid_b = v; in_data_b = d; out_ready_b = r;
        end
    endtask

    task automatic run_block(input vec_t v, input string name);
        int n;
        expand_key(v.key, v.nk, v.which);
        drive(v.which, 1'b1, v.pt, 1'b0);
        chk({name, " ready"}, 128'((v.which == 0) ? in_ready_a : in_ready_b), 128'(1));
        tick();
        drive(v.which, 1'b0, ~v.pt, 1'b0);
        n = 0;
        while (!ov(v.which) && n < 40) begin
            tick();
            n++;
        end
        chk({name, " latency"}, 128'(n + 1), 128'(v.nk + 7));
        chk({name, " ct"}, (v.which == 0) ? out_data_a : out_data_b, v.ct);
        drive(v.which, 1'b0, 128'h0, 1'b1);
        tick();
        drive(v.which, 1'b0, 128'h0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc_cyc [2];
        int   acc_n;
        int   done_n;
        logic got;
        int   n;

        errors = 0;
        checks = 0;
        rst    = 1'b1;
        drive(0, 1'b0, 128'h0, 1'b0);
        drive(1, 1'b0, 128'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            rks_a[i] = '0;
            rks_b[i] = '0;
        end
        build_sbox();

        vecs[0] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 0};
        vecs[1] = '{{128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0};
        vecs[2] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8,
                    128'h00112233445566778899aabbccddeeff,
                    128'h8ea2b7ca516745bfeafc49904b496089, 1};

        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready", 128'(in_ready_a), 128'(1));
        chk("reset out_valid", 128'(out_valid_a), 128'(0));
        chk("reset busy", 128'(busy_a), 128'(0));
        chk("reset out_data", out_data_a, 128'h0);
        chk("reset rk_idx", 128'(rk_idx_a), 128'(0));
        chk("reset nr14 in_ready", 128'(in_ready_b), 128'(1));
        chk("reset nr14 out_data", out_data_b, 128'h0);

        for (int i = 0; i < 3; i++) run_block(vecs[i], $sformatf("vec%0d", i));

        // Round trace on App.B, then hold the result under backpressure.
        expand_key(vecs[0].key, 4, 0);
        drive(0, 1'b1, vecs[0].pt, 1'b0);
        chk("trace rk_idx idle", 128'(rk_idx_a), 128'(0));
        tick();
        drive(0, 1'b0, 128'h0, 1'b0);
        for (int r = 1; r <= NRA; r++) begin
            chk($sformatf("trace rk_idx r%0d", r), 128'(rk_idx_a), 128'(r));
            tick();
            if (r == 1) chk("trace round1 st", sb_in_a, 128'ha49c7ff2689f352b6b5bea43026a5049);
        end
        chk("trace done rk_idx", 128'(rk_idx_a), 128'(0));
        chk("trace out_valid", 128'(out_valid_a), 128'(1));
        drive(0, 1'b1, 128'hdeadbeef, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold out_valid", 128'(out_valid_a), 128'(1));
            chk("hold out_data", out_data_a, vecs[0].ct);
            chk("hold in_ready", 128'(in_ready_a), 128'(0));
        end
        drive(0, 1'b0, 128'h0, 1'b1);
        tick();
        drive(0, 1'b0, 128'h0, 1'b0);
        chk("release in_ready", 128'(in_ready_a), 128'(1));
        chk("release out_valid", 128'(out_valid_a), 128'(0));
        chk("release busy", 128'(busy_a), 128'(0));

        // Back-to-back: in_valid and out_ready held high, key store swapped while in DONE.
        expand_key(vecs[0].key, 4, 0);
        drive(0, 1'b1, vecs[0].pt, 1'b1);
        acc_n  = 0;
        done_n = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        for (int cyc = 0; cyc < 60 && done_n < 2; cyc++) begin
            if (in_valid_a && in_ready_a && acc_n < 2) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
            end
            got = out_valid_a;
            if (got) begin
                chk($sformatf("b2b ct%0d", done_n), out_data_a, vecs[done_n].ct);
                done_n++;
            end
            tick();
            if (got && done_n == 1) begin
                expand_key(vecs[1].key, 4, 0);
                in_data_a = vecs[1].pt;
            end
            if (acc_n == 2) in_valid_a = 1'b0;
        end
        drive(0, 1'b0, 128'h0, 1'b0);
        chk("b2b blocks done", 128'(done_n), 128'(2));
        chk("b2b accept spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(NRA + 2));
        tick();

        // Reset while in ROUND with rnd=5, then a fresh block.
        expand_key(vecs[0].key, 4, 0);
        drive(0, 1'b1, vecs[0].pt, 1'b0);
        tick();
        drive(0, 1'b0, 128'h0, 1'b0);
        n = 0;
        while (rk_idx_a != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        chk("abort reach rnd5", 128'(rk_idx_a), 128'(5));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort in_ready", 128'(in_ready_a), 128'(1));
        chk("abort out_valid", 128'(out_valid_a), 128'(0));
        chk("abort busy", 128'(busy_a), 128'(0));
        chk("abort out_data", out_data_a, 128'h0);
        run_block(vecs[0], "post-abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
